// File: rtl/led_status_ctrl.sv
// Status-LED scheduler: picks the highest-priority requester (latched fault,
// warning, run) and plays its blink pattern from a 1 us timebase.
`timescale 1ns/1ps
module led_status_ctrl #(
    parameter int unsigned TICK_PER_MS   = 1000,
    parameter int unsigned RUN_HALF_MS   = 500,
    parameter int unsigned FAULT_HALF_MS = 100,
    parameter int unsigned WARN_ON_MS    = 100,
    parameter int unsigned WARN_GAP_MS   = 100,
    parameter int unsigned WARN_PAUSE_MS = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       time_1us,
    input  logic       run_en,
    input  logic       warn_req,
    input  logic       fault_req,
    input  logic       fault_clr,
    output logic       led_out,
    output logic [1:0] mode
);

    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_WARN  = 2'd2,
        MODE_FAULT = 2'd3
    } mode_e;

    // r_sync[1:0] is the synchronizer, r_sync[2] the previous synchronized value
    logic [2:0]    r_sync;
    logic [CW-1:0] r_ms_cnt;
    logic [CW-1:0] r_ph_cnt;
    logic [1:0]    r_phase;
    logic          r_fault;
    logic          r_led;
    mode_e         r_mode;

    logic [CW-1:0] w_ms_cnt_nxt;
    logic [CW-1:0] w_ph_cnt_nxt;
    logic [1:0]    w_phase_nxt;
    logic          w_fault_nxt;
    logic          w_led_nxt;
    mode_e         w_mode_nxt;
    mode_e         w_target;
    logic          w_us_pulse;
    logic          w_ms_pulse;
    logic          w_ph_done;
    logic          w_last_phase;
    logic          w_cycle_end;
    logic [CW-1:0] w_ph_len;

    assign w_us_pulse  = r_sync[1] & ~r_sync[2];
    assign w_ms_pulse  = w_us_pulse && (r_mode != MODE_OFF) &&
                         (r_ms_cnt == CW'(TICK_PER_MS - 1));
    assign w_ph_done   = w_ms_pulse && (r_ph_cnt == w_ph_len - 1'b1);
    assign w_cycle_end = w_ph_done && w_last_phase;

    // Length and last-phase flag of the phase currently being played
    always_comb begin
        w_ph_len     = CW'(1);
        w_last_phase = 1'b0;
        case (r_mode)
            MODE_RUN: begin
                w_ph_len     = CW'(RUN_HALF_MS);
                w_last_phase = (r_phase == 2'd1);
            end
            MODE_FAULT: begin
                w_ph_len     = CW'(FAULT_HALF_MS);
                w_last_phase = (r_phase == 2'd1);
            end
            MODE_WARN: begin
                case (r_phase)
                    2'd1:    w_ph_len = CW'(WARN_GAP_MS);
                    2'd3:    w_ph_len = CW'(WARN_PAUSE_MS);
                    default: w_ph_len = CW'(WARN_ON_MS);
                endcase
                w_last_phase = (r_phase == 2'd3);
            end
            default: begin
                w_ph_len     = CW'(1);
                w_last_phase = 1'b0;
            end
        endcase
    end

    // Fault latch next value and highest-priority target (set beats clear)
    always_comb begin
        w_fault_nxt = fault_req | (r_fault & ~fault_clr);
        w_target    = MODE_OFF;
        if (w_fault_nxt) begin
            w_target = MODE_FAULT;
        end else if (warn_req) begin
            w_target = MODE_WARN;
        end else if (run_en) begin
            w_target = MODE_RUN;
        end
    end

    // Next state: pattern sequencing, overridden by preemption or end-of-cycle switch
    always_comb begin
        w_mode_nxt   = r_mode;
        w_phase_nxt  = r_phase;
        w_ph_cnt_nxt = r_ph_cnt;
        w_ms_cnt_nxt = r_ms_cnt;
        w_led_nxt    = r_led;

        if ((r_mode != MODE_OFF) && w_us_pulse) begin
            w_ms_cnt_nxt = w_ms_pulse ? '0 : r_ms_cnt + 1'b1;
        end

        if (w_ms_pulse) begin
            if (w_ph_done) begin
                if (r_mode == MODE_WARN) begin
                    w_phase_nxt = r_phase + 2'd1;
                end else begin
                    w_phase_nxt = {1'b0, ~r_phase[0]};
                end
                w_ph_cnt_nxt = '0;
                // even phases are the lit ones in every pattern
                w_led_nxt    = ~w_phase_nxt[0];
            end else begin
                w_ph_cnt_nxt = r_ph_cnt + 1'b1;
            end
        end

        if ((w_target > r_mode) || ((w_target < r_mode) && w_cycle_end)) begin
            w_mode_nxt   = w_target;
            w_phase_nxt  = 2'd0;
            w_ph_cnt_nxt = '0;
            w_ms_cnt_nxt = '0;
            w_led_nxt    = (w_target != MODE_OFF);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_ms_cnt <= '0;
            r_ph_cnt <= '0;
            r_phase  <= '0;
            r_fault  <= 1'b0;
            r_led    <= 1'b0;
            r_mode   <= MODE_OFF;
        end else begin
            r_sync   <= {r_sync[1:0], time_1us};
            r_ms_cnt <= w_ms_cnt_nxt;
            r_ph_cnt <= w_ph_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_fault  <= w_fault_nxt;
            r_led    <= w_led_nxt;
            r_mode   <= w_mode_nxt;
        end
    end

    assign led_out = r_led;
    assign mode    = r_mode;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Randomized scoreboard bench for led_status_ctrl against a pattern-table model.
`timescale 1ns/1ps
module tb_led_status_ctrl;

    localparam int TPM        = 4;
    localparam int RUN_HALF   = 5;
    localparam int FAULT_HALF = 2;
    localparam int WARN_ON    = 1;
    localparam int WARN_GAP   = 1;
    localparam int WARN_PAUSE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       time_1us = 1'b0;
    logic       run_en = 1'b0;
    logic       warn_req = 1'b0;
    logic       fault_req = 1'b0;
    logic       fault_clr = 1'b0;
    logic       led_out;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // expected {mode, led_out} after each clock edge
    logic [2:0] exp_q[$];

    led_status_ctrl #(
        .TICK_PER_MS  (TPM),
        .RUN_HALF_MS  (RUN_HALF),
        .FAULT_HALF_MS(FAULT_HALF),
        .WARN_ON_MS   (WARN_ON),
        .WARN_GAP_MS  (WARN_GAP),
        .WARN_PAUSE_MS(WARN_PAUSE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .time_1us (time_1us),
        .run_en   (run_en),
        .warn_req (warn_req),
        .fault_req(fault_req),
        .fault_clr(fault_clr),
        .led_out  (led_out),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    // 1 us timebase: 4 clk high / 4 clk low, random starting offset
    initial begin
        repeat ($urandom_range(1, 7)) @(negedge clk);
        forever begin
            repeat (4) @(negedge clk);
            time_1us = ~time_1us;
        end
    end

    // Pattern tables: phase count and phase lengths (ms) per mode
    function automatic int phase_count(input int md);
        return (md == 2) ? 4 : (md == 0) ? 1 : 2;
    endfunction

    function automatic int phase_len(input int md, input int ph);
        case (md)
            1:       return RUN_HALF;
            3:       return FAULT_HALF;
            2:       return (ph == 1) ? WARN_GAP : (ph == 3) ? WARN_PAUSE : WARN_ON;
            default: return 0;
        endcase
    endfunction

    // Reference model: a time_1us rise first seen at edge A is one us tick at edge A+2
    int m_mode = 0, m_phase = 0, m_rem = 0, m_usc = 0;
    bit m_led = 1'b0, m_fault = 1'b0;
    bit smp0 = 1'b0, smp1 = 1'b0, smp2 = 1'b0;

    always @(posedge clk) begin
        bit us_tick, ms_tick, cyc_end;
        int tgt;
        cyc++;
        if (!rst_n) begin
            m_mode = 0; m_phase = 0; m_rem = 0; m_usc = 0;
            m_led = 1'b0; m_fault = 1'b0;
            smp0 = 1'b0; smp1 = 1'b0; smp2 = 1'b0;
        end else begin
            us_tick = smp1 && !smp2;
            smp2 = smp1; smp1 = smp0; smp0 = time_1us;

            ms_tick = 1'b0;
            if (m_mode != 0 && us_tick) begin
                m_usc++;
                if (m_usc == TPM) begin
                    ms_tick = 1'b1;
                    m_usc = 0;
                end
            end

            m_fault = fault_req || (m_fault && !fault_clr);
            tgt = m_fault ? 3 : warn_req ? 2 : run_en ? 1 : 0;
            cyc_end = ms_tick && (m_rem == 1) && (m_phase == phase_count(m_mode) - 1);

            if (tgt > m_mode || (tgt < m_mode && cyc_end)) begin
                m_mode  = tgt;
                m_phase = 0;
                m_rem   = phase_len(tgt, 0);
                m_usc   = 0;
                m_led   = (tgt != 0);
            end else if (ms_tick) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_phase = (m_phase + 1) % phase_count(m_mode);
                    m_rem   = phase_len(m_mode, m_phase);
                    m_led   = (m_phase % 2 == 0);
                end
            end
        end
        exp_q.push_back({2'(m_mode), m_led});
    end

    // Monitor: one expected entry per edge, compared half a cycle later
    always @(negedge clk) begin
        logic [2:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cycle=%0d: no expected entry", cyc);
        end else begin
            e = exp_q.pop_front();
            if ({mode, led_out} !== e) begin
                failures++;
                $display("FAIL pattern cycle=%0d: mode=%0d led=%0b, required mode=%0d led=%0b",
                         cyc, mode, led_out, e[2:1], e[0]);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fault_req();
        fault_req = 1'b1;
        @(negedge clk);
        fault_req = 1'b0;
    endtask

    task automatic pulse_fault_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    // Reset asserted between edges must clear the outputs without a clock
    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mode !== 2'd0 || led_out !== 1'b0) begin
            failures++;
            $display("FAIL %s: mode=%0d led=%0b, required mode=0 led=0", tag, mode, led_out);
        end
        wait_clk(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned r;
        wait_clk(5);
        rst_n = 1'b1;

        // idle, then reset while idle
        wait_clk(500);
        async_reset_check("reset_idle");
        wait_clk(20);

        // RUN for about 20 phases, then withdraw during an on phase
        run_en = 1'b1;
        wait_clk(20 * 160 + $urandom_range(0, 40));
        run_en = 1'b0;
        wait_clk(400);

        // WARN preempts RUN, then falls back at end of pause
        run_en = 1'b1;
        wait_clk($urandom_range(100, 300));
        warn_req = 1'b1;
        wait_clk(600 + $urandom_range(0, 50));
        warn_req = 1'b0;
        wait_clk(400);

        // fault pulse during WARN, latch holds, clear falls back to WARN
        warn_req = 1'b1;
        wait_clk($urandom_range(80, 120));
        pulse_fault_req();
        wait_clk(300);
        pulse_fault_clr();
        wait_clk(300);
        warn_req = 1'b0;
        wait_clk(400);

        // set and clear on the same clock: set wins
        fault_req = 1'b1;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_req = 1'b0;
        fault_clr = 1'b0;
        wait_clk(200);
        pulse_fault_clr();
        wait_clk(300);

        // reset in the middle of a RUN pattern
        wait_clk($urandom_range(50, 200));
        async_reset_check("reset_mid_run");
        wait_clk(300);

        // random request traffic, including requests too short to matter
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                run_en = ~run_en;
            end else if (r < 50) begin
                warn_req = ~warn_req;
            end else if (r < 58) begin
                pulse_fault_req();
            end else if (r < 72) begin
                pulse_fault_clr();
            end else if (r < 80) begin
                warn_req = 1'b1;
                @(negedge clk);
                warn_req = 1'b0;
            end
            wait_clk($urandom_range(5, 60));
        end

        run_en = 1'b0;
        warn_req = 1'b0;
        pulse_fault_clr();
        wait_clk(600);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Status-LED scheduler that shares one board LED between three requesters: fault, warning and run.
- Selects the highest-priority active requester and sequences its blink pattern from the board's free-running 1 µs timebase input.
- Sits beside the power-unit logic. It generalises the plain 500 ms work heartbeat into prioritised, preemptable patterns with a latched fault indication.

Parameters:
TICK_PER_MS, 1000, us ticks per ms tick (2..1023)
RUN_HALF_MS, 500, RUN on time and RUN off time, ms (1..1023)
FAULT_HALF_MS, 100, FAULT on time and FAULT off time, ms (1..1023)
WARN_ON_MS, 100, WARN each-flash on time, ms (1..1023)
WARN_GAP_MS, 100, WARN gap between the two flashes, ms (1..1023)
WARN_PAUSE_MS, 800, WARN off time after the second flash, ms (1..1023)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
time_1us  input  1  asynchronous 1 µs square wave; period ≥ 4 clk
run_en  input  1  level; request RUN heartbeat
warn_req  input  1  level; request WARN double-flash
fault_req  input  1  level; sets the fault latch
fault_clr  input  1  single-clk pulse; clears the fault latch
led_out  output  1  LED drive, 1 = on
mode  output  2  active pattern: 0 OFF, 1 RUN, 2 WARN, 3 FAULT

Behaviour:
- One clock; reset is asynchronous and active-low. All registers, including the synchronizer stages, clear on rst_n low.
- Reset values: led_out=0, mode=0 (OFF), fault latch=0, all counters=0.
- Tick generation:
  - time_1us passes through a 2-flop synchronizer.
  - us_pulse is one clk wide on a synchronized 0→1 transition.
  - The ms counter counts us_pulse from 0 to TICK_PER_MS-1. ms_pulse is one clk wide when us_pulse arrives at count TICK_PER_MS-1; the counter wraps to 0 on that cycle.
- Fault latch:
  - Set on any clk with fault_req=1. Cleared by fault_clr=1 only when fault_req=0; set wins if both are high.
  - While latched, FAULT stays selected even after fault_req drops.
- Target priority: fault latch > warn_req > run_en > OFF.
- Mode change rules, all evaluated each clk:
  - Target of higher priority than mode: switch on the next edge (preempt).
  - Target of lower priority than mode: switch only at the end of the current pattern cycle, i.e. the ms_pulse that ends RUN off, FAULT off or WARN pause.
  - mode=OFF: switch immediately to any target.
- On every switch:
  - mode, led_out and the pattern phase update on the same edge.
  - ms counter and phase counter are cleared, so the new pattern starts with full-length phases.
  - led_out takes the first-phase level of the new mode.
- Pattern phase machine; the phase ms counter increments on ms_pulse and advances at the phase length:
  - OFF: led_out=0, counters held at 0.
  - RUN: ON (RUN_HALF_MS) → OFF (RUN_HALF_MS) → ON …
  - FAULT: ON (FAULT_HALF_MS) → OFF (FAULT_HALF_MS) → ON …
  - WARN: ON1 (WARN_ON_MS, led 1) → GAP (WARN_GAP_MS, 0) → ON2 (WARN_ON_MS, 1) → PAUSE (WARN_PAUSE_MS, 0) → ON1.
- led_out toggles on the same edge as the ms_pulse that completes a phase, and is glitch-free.
- Phase counter is 10 bits. On phase completion it resets to 0; it never wraps past a phase length.
- Reset mid-pattern: everything returns to reset values immediately. After release, the first us_pulse requires a synchronized rising edge of time_1us.
- A request that asserts and drops between two evaluations of the same cycle end has no effect.
- If run_en is withdrawn mid-RUN, RUN finishes its current off phase before mode goes to OFF.

Test Plan:
Common setup: TICK_PER_MS=4, RUN_HALF_MS=5, FAULT_HALF_MS=2, WARN_ON_MS=1, WARN_GAP_MS=1, WARN_PAUSE_MS=3; time_1us = 4 clk high / 4 clk low, giving 1 ms = 32 clk.
- Reset/idle: all requests 0 for 500 clk -> led_out=0, mode=0 throughout; assert rst_n=0 mid-run -> led_out=0, mode=0 asynchronously.
- RUN: run_en=1 at edge k -> mode=1 and led_out=1 after edge k; led_out high 160 clk, low 160 clk, repeating; drop run_en during the on phase -> one full off phase completes, then mode=0.
- WARN: warn_req=1 with run_en=1 -> preempts on next edge, mode=2; led pattern 32 on / 32 off / 32 on / 96 off clk, repeating. Drop warn_req -> mode=1 only at the end of PAUSE.
- FAULT latch: pulse fault_req for 1 clk during WARN -> mode=3 next edge; led_out 64 on / 64 off. The latch holds after fault_req drops. fault_clr pulse -> mode falls to the pending target only at the end of the FAULT off phase.
- Set/clear collision: fault_req=1 and fault_clr=1 on the same clk -> latch remains set, mode=3.
- Tick boundary: a time_1us rising edge coincident with the phase end -> exactly one ms counted per 32 clk; no double count or missed toggle across 20 phases.
